// File: rtl/memory_stage.sv
// memory_stage: RV32 memory stage with ready-based data bus, load/store formatting and branch resolution
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] pc,
  input  logic        dread,
  input  logic [1:0]  dwrite,
  input  logic [1:0]  reg_wr_mem,
  input  logic        reg_wr_mem_signed,
  input  logic [31:0] alu_out,
  input  logic [31:0] rdat2,
  input  logic        alu_zero,
  input  logic        branch_pol,
  input  logic [1:0]  pc_ctrl,
  input  logic [31:0] pc_plus_imm,
  input  logic        branch_predict,
  input  logic [31:0] branch_target,
  output logic        dmem_ren,
  output logic        dmem_wen,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state, state_nx;
  logic        start, flushed, ren_q, wen_q, sgn_q, acc, v, taken;
  logic [1:0]  size_q, off_q;
  logic [3:0]  wstrb_c, wstrb_q;
  logic [31:0] wdata_c, wdata_q, addr_q, sh, fmt, target;
  assign misaligned = ex_valid & ((dread & (reg_wr_mem == 2'd1 ? alu_out[0] : (reg_wr_mem[1] & (|alu_out[1:0]))))
                    | (dwrite == 2'b10 ? alu_out[0] : ((dwrite == 2'b11) & (|alu_out[1:0]))));
  assign start = ex_valid & ~flush & (dread | (|dwrite)) & ~misaligned;
  assign acc = state == ACCESS;
  always_comb begin
    wstrb_c = dwrite == 2'b01 ? 4'b0001 << alu_out[1:0] : dwrite == 2'b10 ? 4'b0011 << alu_out[1:0] :
              dwrite == 2'b11 ? 4'b1111 : 4'b0000;
    wdata_c = dwrite == 2'b01 ? {4{rdat2[7:0]}} : dwrite == 2'b10 ? {2{rdat2[15:0]}} : rdat2;
    sh = dmem_rdata >> {off_q, 3'b000};
    fmt = size_q == 2'd0 ? {{24{sgn_q & sh[7]}}, sh[7:0]} :
          size_q == 2'd1 ? {{16{sgn_q & sh[15]}}, sh[15:0]} : dmem_rdata;
    state_nx = state == IDLE ? (start ? ACCESS : IDLE) :
               acc ? (dmem_ready ? ((flushed | flush) ? IDLE : DONE) : ACCESS) :
               ((en | flush) ? IDLE : DONE);
    mem_stall = state == IDLE ? start : acc & ~dmem_ready;
  end
  assign dmem_ren   = acc & ren_q;
  assign dmem_wen   = acc & wen_q;
  assign dmem_addr  = acc ? addr_q : 32'd0;
  assign dmem_wstrb = acc ? wstrb_q : 4'd0;
  assign dmem_wdata = acc ? wdata_q : 32'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      flushed <= 1'b0;
      load_data <= 32'd0;
      load_valid <= 1'b0;
      ren_q <= 1'b0;
      wen_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        ren_q <= dread;
        wen_q <= |dwrite;
        sgn_q <= reg_wr_mem_signed;
        size_q <= reg_wr_mem;
        off_q <= alu_out[1:0];
        addr_q <= {alu_out[31:2], 2'b00};
        wstrb_q <= wstrb_c;
        wdata_q <= wdata_c;
        flushed <= 1'b0;
        load_valid <= 1'b0;
      end
      if (acc && flush) flushed <= 1'b1;
      if (acc && dmem_ready) begin
        load_data <= fmt;
        load_valid <= ren_q & ~(flushed | flush);
      end
      if (state == DONE && (en || flush)) load_valid <= 1'b0;
    end
  end
  // Branch outcome is only meaningful for a live, unflushed instruction
  assign v = ex_valid & ~flush;
  assign taken = v & (pc_ctrl == 2'd1 ? alu_zero ^ branch_pol : pc_ctrl[1]);
  assign target = pc_ctrl == 2'd3 ? alu_out & ~32'd1 : pc_plus_imm;
  assign mispredict = v & ((taken != branch_predict) | (taken & (target != branch_target)));
  assign redirect_pc = taken ? target : pc + 32'd4;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage
module tb_memory_stage;
  logic        clk = 0, rst, en, flush, ex_valid, dread, reg_wr_mem_signed, alu_zero, branch_pol, branch_predict;
  logic [1:0]  dwrite, reg_wr_mem, pc_ctrl;
  logic [31:0] pc, alu_out, rdat2, pc_plus_imm, branch_target, dmem_rdata;
  logic        dmem_ready, dmem_ren, dmem_wen, mem_stall, load_valid, misaligned, mispredict;
  logic [31:0] dmem_addr, dmem_wdata, load_data, redirect_pc;
  logic [3:0]  dmem_wstrb;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  memory_stage dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .ex_valid(ex_valid), .pc(pc), .dread(dread),
    .dwrite(dwrite), .reg_wr_mem(reg_wr_mem), .reg_wr_mem_signed(reg_wr_mem_signed), .alu_out(alu_out),
    .rdat2(rdat2), .alu_zero(alu_zero), .branch_pol(branch_pol), .pc_ctrl(pc_ctrl), .pc_plus_imm(pc_plus_imm),
    .branch_predict(branch_predict), .branch_target(branch_target), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .mispredict(mispredict), .redirect_pc(redirect_pc)
  );
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic retire;
    ex_valid = 0; dread = 0; dwrite = 0; en = 1;
    tick;
    en = 0;
  endtask
  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sg, input logic [31:0] rd);
    ex_valid = 1; dread = 1; dwrite = 0; reg_wr_mem = sz; reg_wr_mem_signed = sg; alu_out = a;
    tick;
    dmem_ready = 1; dmem_rdata = rd;
    tick;
    dmem_ready = 0;
  endtask
  initial begin
    rst = 1; en = 0; flush = 0; ex_valid = 0; dread = 0; dwrite = 0; reg_wr_mem = 0; reg_wr_mem_signed = 0;
    alu_zero = 0; branch_pol = 0; branch_predict = 0; pc_ctrl = 0; pc = 0; alu_out = 0; rdat2 = 0;
    pc_plus_imm = 0; branch_target = 0; dmem_rdata = 0; dmem_ready = 0;
    tick; tick;
    rst = 0;
    #1;
    chk("rst_stall", mem_stall, 0);
    chk("rst_ren", dmem_ren, 0);
    chk("rst_wen", dmem_wen, 0);
    chk("rst_ldata", load_data, 0);
    chk("rst_lvalid", load_valid, 0);
    // LW 0x100, ready on third stalled cycle
    ex_valid = 1; dread = 1; reg_wr_mem = 2; alu_out = 32'h100;
    #1;
    chk("lw_stall0", mem_stall, 1);
    chk("lw_ren_idle", dmem_ren, 0);
    tick;
    chk("lw_stall1", mem_stall, 1);
    chk("lw_ren", dmem_ren, 1);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_wstrb", dmem_wstrb, 0);
    tick;
    chk("lw_stall2", mem_stall, 1);
    dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_stall_ready", mem_stall, 0);
    tick;
    dmem_ready = 0;
    chk("lw_data", load_data, 32'hDEADBEEF);
    chk("lw_valid", load_valid, 1);
    chk("lw_done_ren", dmem_ren, 0);
    chk("lw_done_stall", mem_stall, 0);
    tick;
    chk("lw_no_reissue", dmem_ren, 0);
    chk("lw_valid_hold", load_valid, 1);
    retire;
    chk("lw_retired", load_valid, 0);
    // Byte and half loads with extension
    load(32'h103, 0, 1, 32'h80123456);
    chk("lb_data", load_data, 32'hFFFFFF80);
    retire;
    load(32'h103, 0, 0, 32'h80123456);
    chk("lbu_data", load_data, 32'h00000080);
    retire;
    load(32'h102, 1, 1, 32'h80011234);
    chk("lh_data", load_data, 32'hFFFF8001);
    retire;
    load(32'h101, 0, 0, 32'h1122C344);
    chk("lbu1_data", load_data, 32'h000000C3);
    retire;
    // SH 0x102: strobes/data held until ready
    ex_valid = 1; dwrite = 2'b10; alu_out = 32'h102; rdat2 = 32'h1234ABCD;
    tick;
    chk("sh_wen", dmem_wen, 1);
    chk("sh_ren", dmem_ren, 0);
    chk("sh_wstrb", dmem_wstrb, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    alu_out = 32'h200; rdat2 = 32'h0;
    tick;
    chk("sh_wen_held", dmem_wen, 1);
    chk("sh_addr_held", dmem_addr, 32'h100);
    chk("sh_wdata_held", dmem_wdata, 32'hABCDABCD);
    dmem_ready = 1;
    tick;
    dmem_ready = 0;
    chk("sh_wen_done", dmem_wen, 0);
    chk("sh_lvalid", load_valid, 0);
    retire;
    ex_valid = 1; dwrite = 2'b01; alu_out = 32'h101; rdat2 = 32'h000000EF;
    tick;
    chk("sb_wstrb", dmem_wstrb, 4'b0010);
    chk("sb_wdata", dmem_wdata, 32'hEFEFEFEF);
    dmem_ready = 1;
    tick;
    dmem_ready = 0;
    retire;
    // Misaligned word load
    ex_valid = 1; dread = 1; reg_wr_mem = 2; alu_out = 32'h101;
    #1;
    chk("mis_flag", misaligned, 1);
    chk("mis_stall", mem_stall, 0);
    tick;
    chk("mis_ren", dmem_ren, 0);
    dread = 0; dwrite = 2'b10; alu_out = 32'h103;
    #1;
    chk("mis_sh", misaligned, 1);
    dwrite = 0; ex_valid = 0;
    // Branch resolution
    ex_valid = 1; pc_ctrl = 1; alu_zero = 1; branch_pol = 0; branch_predict = 0; pc = 32'h40; pc_plus_imm = 32'h80;
    #1;
    chk("beq_mispred", mispredict, 1);
    chk("beq_redirect", redirect_pc, 32'h80);
    branch_predict = 1; branch_target = 32'h80;
    #1;
    chk("beq_pred_ok", mispredict, 0);
    branch_target = 32'h84;
    #1;
    chk("beq_bad_target", mispredict, 1);
    alu_zero = 0; branch_predict = 0;
    #1;
    chk("beq_nt", mispredict, 0);
    chk("beq_nt_redirect", redirect_pc, 32'h44);
    branch_pol = 1;
    #1;
    chk("bne_taken", mispredict, 1);
    pc_ctrl = 3; alu_out = 32'h1235; branch_predict = 1; branch_target = 32'h1234;
    #1;
    chk("jalr_ok", mispredict, 0);
    chk("jalr_redirect", redirect_pc, 32'h1234);
    pc_ctrl = 0; pc = 32'hFFFFFFFC; branch_predict = 0;
    #1;
    chk("wrap_redirect", redirect_pc, 32'h0);
    pc_ctrl = 2; pc_plus_imm = 32'h500; flush = 1;
    #1;
    chk("flush_no_mispred", mispredict, 0);
    flush = 0; pc_ctrl = 0; ex_valid = 0;
    // Flush during ACCESS
    ex_valid = 1; dread = 1; reg_wr_mem = 2; alu_out = 32'h100;
    tick;
    flush = 1;
    #1;
    chk("fl_ren_held", dmem_ren, 1);
    chk("fl_stall_held", mem_stall, 1);
    tick;
    flush = 0;
    chk("fl_ren_held2", dmem_ren, 1);
    dmem_ready = 1; dmem_rdata = 32'h12345678;
    ex_valid = 0; dread = 0;
    tick;
    dmem_ready = 0;
    chk("fl_lvalid", load_valid, 0);
    chk("fl_ren_off", dmem_ren, 0);
    ex_valid = 1; dread = 1;
    #1;
    chk("fl_idle_start", mem_stall, 1);
    // Reset while in ACCESS
    tick;
    chk("rs_ren", dmem_ren, 1);
    rst = 1;
    tick;
    chk("rs_ren_drop", dmem_ren, 0);
    chk("rs_lvalid", load_valid, 0);
    rst = 0; ex_valid = 0; dread = 0;
    tick;
    chk("rs_idle", dmem_ren, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
